alu_mod_sequencer: RTL and testbench
====================================

Name: alu_mod_sequencer

Overview:
- Multi-cycle initiator that drives the shared 32-bit ALU's operand and control inputs.
- Computes the remainder A mod B by repeated ALU compare (SLT) and subtract (SUB) cycles.
- Sits between the datapath control and the combinational ALU.
- Supplies the value for the ALU's currently unpopulated mod slot (alu_ctr 3'b111) as a sequenced result.

Parameters:
- MAX_ITER, 1024: maximum number of SUB steps before the operation aborts with an error.
- ITER_W, 11: width of the iteration counter; must hold MAX_ITER.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  32  dividend; signed, must be non-negative.
- op_b  input  32  divisor; signed, must be positive.
- alu_src1  output  32  ALU operand 1.
- alu_src2  output  32  ALU operand 2.
- alu_ctr  output  3  ALU operation select: 3'b100 SLT, 3'b110 SUB, 3'b000 when idle.
- alu_result  input  32  combinational ALU result, valid in the same cycle.
- busy  output  1  high from the cycle after start is accepted until the DONE cycle inclusive.
- done  output  1  one-cycle pulse; result and err are valid while it is high.
- result  output  32  remainder; held until the next accepted start.
- err  output  1  set for an illegal operand or a timeout; held with result.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - busy=0, done=0, err=0, result=0.
  - alu_src1=0, alu_src2=0, alu_ctr=3'b000.
  - Internal rem, div and iteration count are cleared.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- ALU outputs are a function of the registered state and the internal rem/div registers.
  - CHECK: src1=rem, src2=div, ctr=3'b100.
  - SUB: src1=rem, src2=div, ctr=3'b110.
  - IDLE and DONE: 0, 0, 3'b000.
- IDLE, with start=1:
  - Latch rem<=op_a, div<=op_b, cnt<=0, err<=0.
  - If op_b==0, op_b[31]==1 or op_a[31]==1: go to DONE with err<=1 and result<=0.
  - Otherwise go to CHECK.
- CHECK:
  - If alu_result[0]==1 (rem<div): result<=rem, go to DONE.
  - Otherwise go to SUB.
  - Only bit 0 of alu_result is used.
- SUB:
  - rem<=alu_result, cnt<=cnt+1.
  - If cnt==MAX_ITER-1: go to DONE with err<=1 and result<=0.
  - Otherwise go to CHECK.
- DONE: done=1 and busy=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency, for quotient q≤MAX_ITER-1:
  - Start accepted at edge T0.
  - CHECK/SUB alternate for 2q+1 cycles.
  - done is high in the cycle following edge T0+2q+1, i.e. 2q+2 cycles after acceptance.
  - An illegal operand gives done in the cycle after acceptance.
- start while not in IDLE is ignored; no queueing.
- start in the same cycle DONE is high is ignored; a new start is accepted only in IDLE.
- Arithmetic:
  - All values are 32-bit.
  - rem never goes negative because SUB is issued only after SLT reports rem≥div.
  - a<b gives result=a with q=0.
  - a==b gives result=0 with q=1.
  - cnt wraps never; the abort fires first.

Test Plan:
- Reset check: rst_n=0 for 2 cycles mid-computation (op_a=100, op_b=7) -> the next cycle shows busy=0, done=0, result=0, alu_ctr=3'b000; no done pulse follows.
- Normal case: op_a=17, op_b=5, start pulse -> alu_ctr sequence 100,110,100,110,100,110,100; done pulses 8 cycles after acceptance with result=2, err=0.
- Edge quotients:
  - op_a=3, op_b=9 -> done after 2 cycles, result=3.
  - op_a=9, op_b=9 -> done after 4 cycles, result=0.
- Illegal operands:
  - op_b=0 -> done in the next cycle, err=1, result=0.
  - op_a=32'h8000_0000 -> err=1.
  - The ALU is never driven with a non-idle alu_ctr in either case.
- Timeout: MAX_ITER=4, op_a=100, op_b=1 -> after 4 SUB steps, done=1, err=1, result=0.
- Handshake: start held high throughout a 17 mod 5 operation -> that operation completes unaffected, then a second operation starts only from IDLE; result from the first op stays stable until that acceptance edge.

Source files
------------

// File: rtl/alu_mod_sequencer.sv
// Sequenced A mod B using the shared ALU's SLT and SUB operations.
// Fills the ALU's mod slot with a multi-cycle result and error flag.
module alu_mod_sequencer #(
  parameter int MAX_ITER = 1024,
  parameter int ITER_W   = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [2:0]  alu_ctr,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err
);

  localparam logic [2:0] CTR_IDLE = 3'b000;
  localparam logic [2:0] CTR_SLT  = 3'b100;
  localparam logic [2:0] CTR_SUB  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_SUB,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [31:0]       rem_q;
  logic [31:0]       div_q;
  logic [ITER_W-1:0] cnt_q;
  logic [ITER_W-1:0] cnt_d;
  logic [31:0]       result_q;
  logic              err_q;
  logic              bad_op_d;
  logic              last_d;

  assign cnt_d    = cnt_q + 1'b1;
  assign bad_op_d = (op_b == 32'd0) | op_b[31] | op_a[31];
  assign last_d   = (cnt_q == ITER_W'(MAX_ITER - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_q <= op_a;
            div_q <= op_b;
            cnt_q <= '0;
            err_q <= 1'b0;
            if (bad_op_d) begin
              err_q    <= 1'b1;
              result_q <= '0;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // SLT result: bit 0 set means rem < div
          if (alu_result[0]) begin
            result_q <= rem_q;
            state_q  <= S_DONE;
          end else begin
            state_q  <= S_SUB;
          end
        end
        S_SUB: begin
          rem_q <= alu_result;
          cnt_q <= cnt_d;
          if (last_d) begin
            err_q    <= 1'b1;
            result_q <= '0;
            state_q  <= S_DONE;
          end else begin
            state_q  <= S_CHECK;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    alu_src1 = '0;
    alu_src2 = '0;
    alu_ctr  = CTR_IDLE;
    unique case (state_q)
      S_CHECK: begin
        alu_src1 = rem_q;
        alu_src2 = div_q;
        alu_ctr  = CTR_SLT;
      end
      S_SUB: begin
        alu_src1 = rem_q;
        alu_src2 = div_q;
        alu_ctr  = CTR_SUB;
      end
      default: begin
        alu_ctr  = CTR_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_mod_sequencer.sv
// Bench for alu_mod_sequencer: vector table, random ops vs a % / model,
// reset abort, timeout (small MAX_ITER) and start handshake sequences.
module tb_alu_mod_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start0;
  logic        start1;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic [31:0] s1_0, s2_0, ar0, res0;
  logic [2:0]  ctr0;
  logic        busy0, done0, err0;
  logic [31:0] s1_1, s2_1, ar1, res1;
  logic [2:0]  ctr1;
  logic        busy1, done1, err1;

  int total;
  int bad;
  int sel;

  alu_mod_sequencer #(.MAX_ITER(1024), .ITER_W(11)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .op_a(op_a), .op_b(op_b),
    .alu_src1(s1_0), .alu_src2(s2_0), .alu_ctr(ctr0),
    .alu_result(ar0),
    .busy(busy0), .done(done0), .result(res0), .err(err0)
  );

  alu_mod_sequencer #(.MAX_ITER(4), .ITER_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .op_a(op_a), .op_b(op_b),
    .alu_src1(s1_1), .alu_src2(s2_1), .alu_ctr(ctr1),
    .alu_result(ar1),
    .busy(busy1), .done(done1), .result(res1), .err(err1)
  );

  function automatic logic [31:0] alu(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    logic [31:0] r;
    r = '0;
    if (c == 3'b100) r = {31'b0, $signed(a) < $signed(b)};
    else if (c == 3'b110) r = a - b;
    return r;
  endfunction

  assign ar0 = alu(s1_0, s2_0, ctr0);
  assign ar1 = alu(s1_1, s2_1, ctr1);

  logic        m_done, m_busy, m_err;
  logic [31:0] m_res;
  logic [2:0]  m_ctr;
  assign m_done = (sel == 1) ? done1 : done0;
  assign m_busy = (sel == 1) ? busy1 : busy0;
  assign m_err  = (sel == 1) ? err1  : err0;
  assign m_res  = (sel == 1) ? res1  : res0;
  assign m_ctr  = (sel == 1) ? ctr1  : ctr0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input int s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_res,
                        input logic e_err, input int e_lat,
                        input bit illegal, input string nm);
    int lat;
    bit seq_ok;
    logic [2:0] ec;
    sel  = s;
    op_a = a;
    op_b = b;
    if (s == 1) start1 = 1'b1;
    else start0 = 1'b1;
    step();
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 1;
    seq_ok = 1'b1;
    while (!m_done && lat < 5000) begin
      ec = illegal ? 3'b000 : ((lat % 2 == 1) ? 3'b100 : 3'b110);
      if (m_ctr !== ec) seq_ok = 1'b0;
      step();
      lat++;
    end
    if (m_ctr !== 3'b000) seq_ok = 1'b0;
    chk({nm, "_lat"}, lat, e_lat);
    chk({nm, "_done"}, {31'b0, m_done}, 32'd1);
    chk({nm, "_busy"}, {31'b0, m_busy}, 32'd1);
    chk({nm, "_res"}, m_res, e_res);
    chk({nm, "_err"}, {31'b0, m_err}, {31'b0, e_err});
    chk({nm, "_ctrseq"}, {31'b0, seq_ok}, 32'd1);
    step();
    chk({nm, "_idle"}, {31'b0, m_busy | m_done}, 32'd0);
    chk({nm, "_hold"}, m_res, e_res);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
    bit          illegal;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    bit seen;
    logic [31:0] a, b, q, r;
    bit ill;
    total  = 0;
    bad    = 0;
    sel    = 0;
    start0 = 1'b0;
    start1 = 1'b0;
    op_a   = '0;
    op_b   = '0;

    vecs[0] = '{32'd17, 32'd5, 32'd2, 1'b0, 8, 1'b0};
    vecs[1] = '{32'd3, 32'd9, 32'd3, 1'b0, 2, 1'b0};
    vecs[2] = '{32'd9, 32'd9, 32'd0, 1'b0, 4, 1'b0};
    vecs[3] = '{32'd12, 32'd0, 32'd0, 1'b1, 1, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'd5, 32'd0, 1'b1, 1, 1'b1};
    vecs[5] = '{32'd5, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1'b1};
    vecs[6] = '{32'd0, 32'd7, 32'd0, 1'b0, 2, 1'b0};
    vecs[7] = '{32'd100, 32'd33, 32'd1, 1'b0, 8, 1'b0};

    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", {31'b0, busy0}, 32'd0);
    chk("rst_done", {31'b0, done0}, 32'd0);
    chk("rst_err", {31'b0, err0}, 32'd0);
    chk("rst_res", res0, 32'd0);
    chk("rst_src", s1_0 | s2_0, 32'd0);
    chk("rst_ctr", {29'b0, ctr0}, 32'd0);
    chk("rst1_busy", {31'b0, busy1}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++)
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err,
             vecs[i].lat, vecs[i].illegal, $sformatf("vec%0d", i));

    run_op(1, 32'd100, 32'd1, 32'd0, 1'b1, 9, 1'b0, "timeout");
    run_op(1, 32'd3, 32'd1, 32'd0, 1'b0, 8, 1'b0, "maxq");
    run_op(1, 32'd4, 32'd1, 32'd0, 1'b1, 9, 1'b0, "qeqmax");

    for (int i = 0; i < 24; i++) begin
      b = $urandom_range(1000, 1);
      q = $urandom_range(40, 0);
      r = $urandom_range(b - 1, 0);
      a = b * q + r;
      if (i % 6 == 5) b = 32'd0;
      if (i % 6 == 2) a = a | 32'h8000_0000;
      if (i % 6 == 4) b = b | 32'h8000_0000;
      ill = (b == 0) || $signed(b) < 0 || $signed(a) < 0;
      if (ill)
        run_op(0, a, b, 32'd0, 1'b1, 1, 1'b1, $sformatf("rnd%0d", i));
      else
        run_op(0, a, b, a % b, 1'b0, 2 * int'(a / b) + 2, 1'b0,
               $sformatf("rnd%0d", i));
    end

    sel  = 0;
    op_a = 32'd100;
    op_b = 32'd7;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    step();
    chk("mrst_busy", {31'b0, busy0}, 32'd0);
    chk("mrst_done", {31'b0, done0}, 32'd0);
    chk("mrst_res", res0, 32'd0);
    chk("mrst_ctr", {29'b0, ctr0}, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      step();
      if (done0 || busy0) seen = 1'b1;
    end
    chk("mrst_nodone", {31'b0, seen}, 32'd0);

    op_a = 32'd17;
    op_b = 32'd5;
    start0 = 1'b1;
    step();
    lat = 1;
    while (!done0 && lat < 100) begin
      step();
      lat++;
    end
    chk("hs_lat", lat, 8);
    chk("hs_res", res0, 32'd2);
    op_a = 32'd9;
    op_b = 32'd9;
    step();
    chk("hs_idle", {31'b0, busy0}, 32'd0);
    chk("hs_hold", res0, 32'd2);
    step();
    chk("hs_accept", {31'b0, busy0}, 32'd1);
    chk("hs_hold2", res0, 32'd2);
    chk("hs_errclr", {31'b0, err0}, 32'd0);
    start0 = 1'b0;
    lat = 1;
    while (!done0 && lat < 100) begin
      step();
      lat++;
    end
    chk("hs2_lat", lat, 4);
    chk("hs2_res", res0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
